// File: rtl/key_pkg.sv
// Shared types and constants for the pushbutton debounce reader.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Raw key_in level when the button is not pressed.
    localparam logic RELEASED_ACTIVE_LOW  = 1'b1;
    localparam logic RELEASED_ACTIVE_HIGH = 1'b0;

    function automatic logic released_level(input logic active_low);
        return active_low ? RELEASED_ACTIVE_LOW : RELEASED_ACTIVE_HIGH;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the asynchronous key input.
module key_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_reader.sv
// Debounced pushbutton reader: level, press/release pulses, press counter.
// Optional long-press pulse is built when KEY_LONG_PRESS_EN is defined.
module key_debounce_reader
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [2:0] press_count
);

    localparam int unsigned     DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic            RELEASED = released_level(KEY_ACTIVE_LOW);
    // Transition fires on the sample that brings the count to DEBOUNCE_CYCLES-1.
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 2);

    logic            synced;
    logic            pressed;
    key_state_t      state;
    key_state_t      state_nxt;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic            press_nxt;
    logic            release_nxt;

    key_sync #(
        .RESET_VAL (RESET_VAL_OF(RELEASED))
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (synced)
    );

    assign pressed = synced ^ RELEASED;

    always_comb begin
        state_nxt   = state;
        db_cnt_nxt  = db_cnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt  = PRESS_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_nxt  = IDLE;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt  = HELD;
                    db_cnt_nxt = '0;
                    press_nxt  = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_nxt  = RELEASE_WAIT;
                    db_cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_nxt  = HELD;
                    db_cnt_nxt = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    db_cnt_nxt  = '0;
                    release_nxt = 1'b1;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                db_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            db_cnt      <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            press_count <= 3'd0;
        end else begin
            state       <= state_nxt;
            db_cnt      <= db_cnt_nxt;
            key_level   <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
            key_press   <= press_nxt;
            key_release <= release_nxt;
            if (press_nxt) begin
                press_count <= press_count + 3'd1;
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned     LG_W    = $clog2(LONG_CYCLES);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

    logic [LG_W-1:0] long_cnt;
    logic [LG_W-1:0] long_cnt_nxt;
    logic            long_nxt;

    // Restarts on each accepted press, survives release glitches, saturates.
    always_comb begin
        long_cnt_nxt = long_cnt;
        long_nxt     = 1'b0;
        if (press_nxt) begin
            long_cnt_nxt = '0;
        end else if (((state == HELD) || (state == RELEASE_WAIT)) && (long_cnt != LG_LAST)) begin
            long_cnt_nxt = long_cnt + LG_W'(1);
            long_nxt     = (long_cnt_nxt == LG_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            long_cnt <= long_cnt_nxt;
            key_long <= long_nxt;
        end
    end
`else
    assign key_long = 1'b0;
`endif

    function automatic logic RESET_VAL_OF(input logic lvl);
        return lvl;
    endfunction

endmodule

// File: tb/tb_key_debounce_reader.sv
// Directed bench for key_debounce_reader (DEBOUNCE_CYCLES=8, LONG_CYCLES=40, active-low key).
module tb_key_debounce_reader;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       key_level;
    logic       key_press;
    logic       key_release;
    logic       key_long;
    logic [2:0] press_count;

    int checks = 0;
    int errors = 0;

    int edge_no = 0;
    int press_seen = 0;
    int release_seen = 0;
    int long_seen = 0;
    int last_press_edge = 0;
    int last_long_edge = 0;
    int consec = 0;
    logic prev_press = 1'b0;
    logic prev_release = 1'b0;
    logic prev_long = 1'b0;

`ifdef KEY_LONG_PRESS_EN
    localparam int EXP_LONG = 1;
`else
    localparam int EXP_LONG = 0;
`endif

    key_debounce_reader #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (40),
        .KEY_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .press_count (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (key_press) begin
            press_seen++;
            last_press_edge = edge_no;
        end
        if (key_release) release_seen++;
        if (key_long) begin
            long_seen++;
            last_long_edge = edge_no;
        end
        if ((key_press && prev_press) || (key_release && prev_release) || (key_long && prev_long))
            consec++;
        prev_press   = key_press;
        prev_release = key_release;
        prev_long    = key_long;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        int base;
        int low;
        int rel;
        int rel_before;

        rst    = 1'b1;
        key_in = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", {key_level, key_press, key_release, key_long, press_count}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_level", key_level, 32'd0);

        // Clean press, then hold 100 cycles for the long-press check
        base   = edge_no;
        key_in = 1'b0;
        repeat (9) @(negedge clk);
        check("press_early", {key_press, key_level}, 32'd0);
        @(negedge clk);
        check("press_edge10", {key_press, key_level, press_count}, {27'd0, 1'b1, 1'b1, 3'd1});
        @(negedge clk);
        check("press_one_cycle", {key_press, key_level}, 32'd1);
        repeat (99) @(negedge clk);
        check("long_count", long_seen, EXP_LONG);
`ifdef KEY_LONG_PRESS_EN
        check("long_edge", last_long_edge, base + 49);
`else
        check("long_edge", last_long_edge, 32'd0);
`endif
        check("press_once", press_seen, 32'd1);
        check("press_edge_mon", last_press_edge, base + 10);

        // Clean release
        key_in = 1'b1;
        repeat (9) @(negedge clk);
        check("release_early", {key_release, key_level}, 32'd1);
        @(negedge clk);
        check("release_edge10", {key_release, key_level, press_count}, {27'd0, 1'b1, 1'b0, 3'd1});

        // Bouncy press: toggle every 3 cycles for 30 cycles, then hold low
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            key_in = (i % 2 == 1);
            repeat (3) @(negedge clk);
        end
        check("bounce_no_press", press_seen, 32'd1);
        check("bounce_no_release", release_seen, 32'd1);
        key_in = 1'b0;
        repeat (9) @(negedge clk);
        check("bounce_press_early", key_press, 32'd0);
        @(negedge clk);
        check("bounce_press_edge10", {key_press, press_count}, {28'd0, 1'b1, 3'd2});
        @(negedge clk);

        // Release glitch: 5 cycles high, 20 low, then a real release
        low = 0;
        rel = 0;
        for (int i = 0; i < 25; i++) begin
            key_in = (i < 5);
            @(negedge clk);
            if (!key_level) low++;
            if (key_release) rel++;
        end
        check("glitch_level_held", low, 32'd0);
        check("glitch_no_release", rel, 32'd0);
        key_in = 1'b1;
        repeat (9) @(negedge clk);
        check("glitch_release_early", {key_release, key_level}, 32'd1);
        @(negedge clk);
        check("glitch_release_edge10", {key_release, key_level}, 32'd2);

        // Reset while held
        repeat (2) @(negedge clk);
        key_in = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_press", {key_press, press_count}, {28'd0, 1'b1, 3'd3});
        repeat (3) @(negedge clk);
        rel_before = release_seen;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset_outputs", {key_level, key_press, key_release, key_long, press_count}, 32'd0);
        end
        rst = 1'b0;
        repeat (9) @(negedge clk);
        check("post_reset_early", key_press, 32'd0);
        @(negedge clk);
        check("post_reset_press", {key_press, key_level, press_count}, {27'd0, 1'b1, 1'b1, 3'd1});
        check("reset_no_release", release_seen, rel_before);
        key_in = 1'b1;
        repeat (12) @(negedge clk);

        // Counter wrap over 9 press/release pairs from zero
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            key_in = 1'b0;
            repeat (10) @(negedge clk);
            check("wrap_press", {key_press, press_count}, {28'd0, 1'b1, 3'(i + 1)});
            key_in = 1'b1;
            repeat (10) @(negedge clk);
            check("wrap_release", key_release, 32'd1);
        end

        repeat (2) @(negedge clk);
        check("no_back_to_back_pulses", consec, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
